// File: rtl/cpu_pkg.sv
// Shared CPU constants: default widths, branch-target table FSM encoding and
// the built-in target values loaded after reset or clear.
package cpu_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int TGT_W_DEF  = 11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } lut_state_e;

  localparam int unsigned DEF_TGT_0 = 19;
  localparam int unsigned DEF_TGT_1 = 27;
  localparam int unsigned DEF_TGT_2 = 34;
  localparam int unsigned DEF_TGT_3 = 39;
  localparam int unsigned DEF_TGT_4 = 51;
  localparam int unsigned DEF_TGT_5 = 74;
  localparam int unsigned DEF_TGT_6 = 76;
  localparam int unsigned DEF_TGT_7 = 83;

  function automatic int unsigned default_target(input int unsigned idx);
    case (idx)
      0:       return DEF_TGT_0;
      1:       return DEF_TGT_1;
      2:       return DEF_TGT_2;
      3:       return DEF_TGT_3;
      4:       return DEF_TGT_4;
      5:       return DEF_TGT_5;
      6:       return DEF_TGT_6;
      7:       return DEF_TGT_7;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/target_lut_defaults.sv
// Combinational index-to-default-target map feeding the init sequencer;
// values wider than TGT_W are truncated.
module target_lut_defaults
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int TGT_W  = TGT_W_DEF
) (
  input  logic [ADDR_W-1:0] i_idx,
  output logic [TGT_W-1:0]  o_data
);

  logic [31:0] w_idx32;

  assign w_idx32 = 32'(i_idx);
  assign o_data  = TGT_W'(default_target(w_idx32));

endmodule

// File: rtl/target_lut.sv
// Programmable branch-target table: init sequencer loads defaults, then a
// synchronous write port and a registered, write-first bypassed read port.
module target_lut
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int TGT_W  = TGT_W_DEF,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Clear,
  output logic              Ready,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [TGT_W-1:0]  Target,
  output logic              RdValid,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [TGT_W-1:0]  WrData,
  output logic              WrErr
);

  localparam int              MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  lut_state_e         r_state;
  logic [ADDR_W:0]    r_idx;
  logic [TGT_W-1:0]   r_mem [DEPTH];

  logic               w_run;
  logic               w_rd_in;
  logic               w_wr_in;
  logic               w_wr_ok;
  logic               w_init_wr;
  logic [TGT_W-1:0]   w_def_data;
  logic               w_mem_we;
  logic [MEM_AW-1:0]  w_mem_addr;
  logic [TGT_W-1:0]   w_mem_data;
  logic [TGT_W-1:0]   w_rd_data;

  target_lut_defaults #(
    .ADDR_W (ADDR_W),
    .TGT_W  (TGT_W)
  ) u_defaults (
    .i_idx  (r_idx[ADDR_W-1:0]),
    .o_data (w_def_data)
  );

  assign w_run     = (r_state == ST_RUN);
  assign w_rd_in   = ({1'b0, RdAddr} < DEPTH_L);
  assign w_wr_in   = ({1'b0, WrAddr} < DEPTH_L);
  assign w_wr_ok   = w_run && !Clear && WrEn && w_wr_in;
  assign w_init_wr = !w_run && !Clear;

  // Single storage write port shared by the init sequencer and the user port.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = '0;
    w_mem_data = '0;
    if (w_init_wr) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_idx[MEM_AW-1:0];
      w_mem_data = w_def_data;
    end else if (w_wr_ok) begin
      w_mem_we   = 1'b1;
      w_mem_addr = WrAddr[MEM_AW-1:0];
      w_mem_data = WrData;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (w_rd_in) begin
      if (w_wr_ok && (WrAddr == RdAddr)) begin
        w_rd_data = WrData;
      end else begin
        w_rd_data = r_mem[RdAddr[MEM_AW-1:0]];
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
      Ready   <= 1'b0;
      Target  <= '0;
      RdValid <= 1'b0;
      WrErr   <= 1'b0;
    end else begin
      WrErr   <= WrEn && (!w_run || Clear || !w_wr_in);
      RdValid <= 1'b0;
      if (Clear) begin
        r_state <= ST_INIT;
        r_idx   <= '0;
        Ready   <= 1'b0;
      end else if (!w_run) begin
        if (r_idx == LAST_L) begin
          r_state <= ST_RUN;
          Ready   <= 1'b1;
        end
        r_idx <= r_idx + ONE_L;
      end else if (RdEn) begin
        Target  <= w_rd_data;
        RdValid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/target_lut.md
# target_lut

Programmable branch-target table for the processor's fetch stage: maps a short pointer from a branch instruction to a full-width PC target. After every reset or clear, an internal init sequencer loads the default contents, so programs that only use the built-in targets need no setup. Software or the test harness can then rewrite entries through a synchronous write port. Reads are registered: one cycle of latency, with a same-cycle write-to-read bypass.

## Interface
- `ADDR_W`, default 5: pointer width; legal range 1..5 (table never exceeds 32 entries).
- `TGT_W`, default 11: target width in bits.
- `DEPTH`, default 2**ADDR_W: number of implemented entries; legal range 1..2**ADDR_W.
- `CLK`  in  1: single clock; all state updates on rising edge.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `Clear`  in  1: synchronous request to restart the init sequence.
- `Ready`  out  1: high when init is complete and the table accepts reads and writes.
- `RdEn`  in  1: read request.
- `RdAddr`  in  ADDR_W: read pointer.
- `Target`  out  TGT_W: registered read data.
- `RdValid`  out  1: `Target` holds the result of the read issued on the previous cycle.
- `WrEn`  in  1: write request.
- `WrAddr`  in  ADDR_W: write pointer.
- `WrData`  in  TGT_W: write data.
- `WrErr`  out  1: one-cycle pulse; the previous cycle's write was rejected.

## Operation
- FSM states: INIT and RUN.
- **Reset.** Asynchronous entry to INIT with init index 0. Reset values:
  - `Ready` = 0, `Target` = 0, `RdValid` = 0, `WrErr` = 0.
  - Entry storage is not reset; the init sequence overwrites it.
- **INIT.**
  - Each cycle writes `default(idx)` to entry `idx`, then increments `idx`.
  - After writing entry DEPTH-1, moves to RUN; `Ready` rises on that same edge.
  - Default contents:
    - entries 0..7 = 19, 27, 34, 39, 51, 74, 76, 83 (each truncated to TGT_W bits);
    - all other entries = 0;
    - only entries below DEPTH are written.
- **Requests during INIT.**
  - `RdEn` is ignored: `RdValid` stays 0 and `Target` holds its value.
  - `WrEn` is rejected: `WrErr` pulses on the next cycle.
- **Clear.**
  - In RUN: moves to INIT with `idx` = 0. `Ready` drops on the next edge.
  - In INIT: restarts the sequence at `idx` = 0.
  - Any read or write presented in the same cycle as `Clear` is ignored. A write in that cycle also pulses `WrErr`.
- **RUN read.**
  - `RdEn` = 1 registers `Target` = entry[`RdAddr`] and sets `RdValid` = 1 on the next edge.
  - `RdEn` = 0: `RdValid` = 0 on the next edge and `Target` holds.
  - `RdAddr` ≥ DEPTH: `Target` = 0 with `RdValid` = 1.
- **RUN write.**
  - `WrEn` = 1 with `WrAddr` < DEPTH: entry updated on the edge.
  - `WrAddr` ≥ DEPTH: write dropped, `WrErr` pulses on the next cycle.
- **Simultaneous read and write, same in-range address.** `Target` returns `WrData` (write-first bypass).
- **Simultaneous read and write, different addresses.** Both complete independently.
- **Width rules.** No arithmetic on targets; data is stored and returned exactly as TGT_W bits. `idx` is ADDR_W+1 bits wide so that DEPTH = 32 terminates cleanly.

## Timing
- Init latency: exactly DEPTH cycles from the first rising edge after `Reset_n` deasserts (or after the edge that samples `Clear`) to `Ready` = 1.
- Read latency: 1 cycle. The request is sampled at edge N; `Target`/`RdValid` are valid after edge N.
- Write takes effect at the sampling edge. A read of that address at edge N+1 returns the new value.
- `Reset_n` asserted mid-operation: all outputs clear immediately (asynchronously), and the in-flight read is lost.
- Back-to-back reads: one per cycle, no bubbles.

## Structure
- A shared package (`cpu_pkg`) holds:
  - the default ADDR_W and TGT_W constants;
  - the FSM state encoding (INIT, RUN);
  - the default-target constants.
- One sub-module, `target_lut_defaults`: a combinational map from index to default value, parametrised by ADDR_W and TGT_W. The init sequencer uses it as its data source.
- Storage is a register array with DEPTH entries, one write port and one read port.

## Test plan
- Reset with DEPTH = 32: `Ready` stays 0 for 32 cycles, then rises. Reads of 0, 3 and 7 return 19, 39 and 83 with `RdValid` = 1, one cycle after each request.
- In RUN, write 1234 to entry 5 (truncated to 11 bits: 1234). Read entry 5 on the next cycle → 1234. Read entry 6 → 76.
- Same-cycle write of 500 and read, both to entry 2 → `Target` = 500. Entry 2 reads 500 afterwards.
- Build with DEPTH = 8, ADDR_W = 5: a write to address 20 gives a `WrErr` pulse and no state change; a read of address 20 returns `Target` = 0 with `RdValid` = 1.
- After modifying entry 0, assert `Clear`: `Ready` drops for DEPTH cycles, then entry 0 reads 19 again. A write issued during INIT pulses `WrErr`.
- Assert `Reset_n` low mid-INIT (at `idx` = 10) and mid-read: outputs are 0 immediately. After release, the full DEPTH-cycle init runs again.
